// File: rtl/maj_chk_pkg.sv
// Shared types and golden functions for the 3-input majority/parity response checker.
package maj_chk_pkg;
  localparam int VEC_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction
endpackage

// File: rtl/maj_ref_model.sv
// Combinational golden model: carry (majority) and sum (parity) of three bits.
module maj_ref_model
  import maj_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic exp_x,
  output logic exp_y
);
  assign exp_x = maj3(a, b, c);
  assign exp_y = par3(a, b, c);
endmodule

// File: rtl/majority_resp_checker.sv
// Response monitor for a majority/full-adder DUT: 2-stage sample+compare, pass/fail counts, first-fail capture.
// Optional RUN watchdog is built when CHECK_TIMEOUT_EN is defined.
module majority_resp_checker
  import maj_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             vec_c,
  input  logic             dut_x,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [4:0]       first_fail_vec,
  output logic             first_fail_valid,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             r_state;
  logic [CNT_W-1:0]   r_vec_cnt;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_fail_cnt;
  logic               r_s1_valid;
  logic [VEC_W-1:0]   r_s1_vec;
  logic [VEC_W-1:0]   r_ff_vec;
  logic               r_ff_valid;
  logic               r_timeout;

  logic w_start_run;
  logic w_accept;
  logic w_last;
  logic w_expire;
  logic w_exp_x;
  logic w_exp_y;
  logic w_mismatch;

  assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept    = vec_valid && (r_state == ST_RUN);
  assign w_last      = w_accept && (r_vec_cnt == LAST_IDX);

`ifdef CHECK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] r_idle_cnt;

  // Expire on the TIMEOUT_CYC-th consecutive idle RUN cycle.
  assign w_expire = (r_state == ST_RUN) && !vec_valid &&
                    (r_idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != ST_RUN) || vec_valid) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start) r_state <= ST_RUN;
        ST_RUN:           if (w_last || w_expire) r_state <= ST_DRAIN;
        default:          r_state <= ST_DONE;
      endcase
    end
  end

  maj_ref_model u_ref (
    .a     (r_s1_vec[4]),
    .b     (r_s1_vec[3]),
    .c     (r_s1_vec[2]),
    .exp_x (w_exp_x),
    .exp_y (w_exp_y)
  );

  assign w_mismatch = (r_s1_vec[1] != w_exp_x) || (r_s1_vec[0] != w_exp_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt  <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_s1_valid <= 1'b0;
      r_s1_vec   <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_start_run) begin
      r_vec_cnt  <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_s1_valid <= 1'b0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_vec_cnt <= r_vec_cnt + 1'b1;
        r_s1_vec  <= {vec_a, vec_b, vec_c, dut_x, dut_y};
      end
      if (w_expire) r_timeout <= 1'b1;
      // Stage 2: the previous cycle's sample is judged here, so DRAIN lands the last one.
      if (r_s1_valid) begin
        if (w_mismatch) begin
          if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + 1'b1;
          if (!r_ff_valid) begin
            r_ff_vec   <= r_s1_vec;
            r_ff_valid <= 1'b1;
          end
        end else if (r_pass_cnt != CNT_MAX) begin
          r_pass_cnt <= r_pass_cnt + 1'b1;
        end
      end
    end
  end

  assign busy             = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done             = (r_state == ST_DONE);
  assign pass             = done && (r_fail_cnt == '0) && !r_timeout;
  assign pass_cnt         = r_pass_cnt;
  assign fail_cnt         = r_fail_cnt;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;
  assign timeout          = r_timeout;
endmodule

// File: tb/tb_majority_resp_checker.sv
// Bench for majority_resp_checker: sweep table, corner sequences, randomized runs vs. arithmetic model.
module tb_majority_resp_checker;
  localparam int NV = 8;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          vec_valid = 1'b0;
  logic          vec_a = 1'b0, vec_b = 1'b0, vec_c = 1'b0, dut_x = 1'b0, dut_y = 1'b0;
  logic          busy, done, pass, first_fail_valid, timeout;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [4:0]    first_fail_vec;

  majority_resp_checker #(.NUM_VECTORS(NV), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec_a(vec_a), .vec_b(vec_b), .vec_c(vec_c), .dut_x(dut_x), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] x_flip;
    logic [7:0] y_flip;
    int         gap;
    bit         start_in_run;
    bit         drain_vec;
    bit         late_vec;
    int         exp_pass_cnt;
    int         exp_fail_cnt;
    logic [4:0] exp_ffv;
    logic       exp_ffvalid;
    logic       exp_pass;
  } sweep_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [4:0] v);
    {vec_a, vec_b, vec_c, dut_x, dut_y} = v;
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
  endtask

  function automatic logic [4:0] good_vec(input int i);
    int s;
    s = i[2] + i[1] + i[0];
    return {i[2], i[1], i[0], (s >= 2) ? 1'b1 : 1'b0, s[0]};
  endfunction

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
    chk({nm, "_done_reached"}, done, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_pass_cnt"}, pass_cnt, 0);
    chk({nm, "_fail_cnt"}, fail_cnt, 0);
    chk({nm, "_ffv"}, first_fail_vec, 0);
    chk({nm, "_ffvalid"}, first_fail_valid, 0);
    chk({nm, "_timeout"}, timeout, 0);
  endtask

  task automatic run_sweep(input sweep_t t, input int idx);
    string nm;
    logic [4:0] v;
    nm = $sformatf("sweep%0d", idx);
    start_pulse();
    for (int i = 0; i < NV; i++) begin
      v = good_vec(i);
      v[1] = v[1] ^ t.x_flip[i];
      v[0] = v[0] ^ t.y_flip[i];
      if (t.start_in_run && i == 2) start = 1'b1;
      feed(v);
      start = 1'b0;
      if (i < NV - 1) repeat (t.gap) step();
    end
    if (t.drain_vec) begin
      {vec_a, vec_b, vec_c, dut_x, dut_y} = 5'b00010;
      vec_valid = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_drain_busy"}, busy, 1);
    chk({nm, "_drain_done"}, done, 0);
    step();
    vec_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_pass_cnt"}, pass_cnt, t.exp_pass_cnt);
    chk({nm, "_fail_cnt"}, fail_cnt, t.exp_fail_cnt);
    chk({nm, "_ffvalid"}, first_fail_valid, t.exp_ffvalid);
    if (t.exp_ffvalid) chk({nm, "_ffv"}, first_fail_vec, t.exp_ffv);
    chk({nm, "_pass"}, pass, t.exp_pass);
    chk({nm, "_timeout"}, timeout, 0);
    if (t.late_vec) begin
      step();
      feed(5'b11100);
      step();
      @(negedge clk);
      chk({nm, "_late_done"}, done, 1);
      chk({nm, "_late_fail_cnt"}, fail_cnt, t.exp_fail_cnt);
      chk({nm, "_late_pass_cnt"}, pass_cnt, t.exp_pass_cnt);
    end
    step();
  endtask

  sweep_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0] q[$];
    int exp_p, exp_f, s;
    logic [4:0] exp_ffv, v;
    logic exp_ffvalid;

    tbl[0] = '{8'h00, 8'h00, 0, 0, 0, 0, 8, 0, 5'b00000, 1'b0, 1'b1};
    tbl[1] = '{8'h08, 8'h00, 0, 0, 0, 0, 7, 1, 5'b01100, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h42, 0, 0, 0, 0, 6, 2, 5'b00100, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 3, 1, 1, 1, 8, 0, 5'b00000, 1'b0, 1'b1};
    tbl[4] = '{8'h01, 8'h80, 1, 0, 0, 1, 6, 2, 5'b00010, 1'b1, 1'b0};

    // Reset state
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 5; k++) run_sweep(tbl[k], k);

    // Mid-run asynchronous reset with a failure recorded, checked before any edge
    start_pulse();
    feed(good_vec(0));
    feed(good_vec(1) ^ 5'b00010);
    feed(good_vec(2));
    feed(good_vec(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // start with vec_valid in IDLE: the faulty vector must not be accepted
    {vec_a, vec_b, vec_c, dut_x, dut_y} = 5'b00010;
    vec_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    vec_valid = 1'b0;
    feed(good_vec(0));
    @(negedge clk);
    chk("lat_edge1_pass_cnt", pass_cnt, 0);
    step();
    @(negedge clk);
    chk("lat_edge2_pass_cnt", pass_cnt, 1);
    for (int i = 1; i < NV; i++) feed(good_vec(i));
    wait_done("afterrst");
    chk("afterrst_pass_cnt", pass_cnt, 8);
    chk("afterrst_fail_cnt", fail_cnt, 0);
    chk("afterrst_pass", pass, 1);
    step();

    // Randomized runs against an arithmetic model
    for (int r = 0; r < 12; r++) begin
      q = {};
      start_pulse();
      for (int i = 0; i < NV; i++) begin
        v = 5'($urandom);
        if ($urandom_range(3) != 0) begin
          s = v[4] + v[3] + v[2];
          v[1] = (s >= 2);
          v[0] = s[0];
        end
        q.push_back(v);
        feed(v);
        repeat ($urandom_range(3)) begin
          {vec_a, vec_b, vec_c, dut_x, dut_y} = 5'($urandom);
          step();
        end
      end
      exp_p = 0;
      exp_f = 0;
      exp_ffvalid = 1'b0;
      exp_ffv = '0;
      foreach (q[j]) begin
        s = q[j][4] + q[j][3] + q[j][2];
        if (q[j][1] == (s >= 2) && q[j][0] == s[0]) exp_p++;
        else begin
          exp_f++;
          if (!exp_ffvalid) begin
            exp_ffvalid = 1'b1;
            exp_ffv = q[j];
          end
        end
      end
      wait_done("rand");
      @(negedge clk);
      chk("rand_pass_cnt", pass_cnt, exp_p);
      chk("rand_fail_cnt", fail_cnt, exp_f);
      chk("rand_ffvalid", first_fail_valid, exp_ffvalid);
      if (exp_ffvalid) chk("rand_ffv", first_fail_vec, exp_ffv);
      chk("rand_pass", pass, (exp_f == 0));
      step();
    end

`ifdef CHECK_TIMEOUT_EN
    begin
      int n;
      start_pulse();
      for (int i = 0; i < 3; i++) feed(good_vec(i));
      n = 0;
      while (!done && n < 60) begin
        step();
        n++;
      end
      chk("to_latency", n, TO + 1);
      chk("to_done", done, 1);
      chk("to_timeout", timeout, 1);
      chk("to_pass", pass, 0);
      chk("to_pass_cnt", pass_cnt, 3);
      chk("to_fail_cnt", fail_cnt, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
